// File: rtl/detector_stepper_pkg.sv
// Shared state encodings and default sizing for the sequence-detector run controller.
package stepper_pkg;

    localparam int DEF_PAT_W         = 16;
    localparam int DEF_LEN_W         = 5;
    localparam int DEF_CNT_W         = 5;
    localparam int DEF_TICKS_PER_BIT = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_DRIVE  = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Counter width that still yields at least one bit for degenerate sizes.
    function automatic int width_for(input int unsigned count);
        return (count > 32'd1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/detector_stepper_if.sv
// Serial link between the run controller (master) and the sequence detector (slave).
interface detector_stepper_if;

    logic det_w;
    logic det_step;
    logic det_clear;
    logic det_z;

    modport master (output det_w, output det_step, output det_clear, input det_z);
    modport slave  (input det_w, input det_step, input det_clear, output det_z);

endinterface

// File: rtl/detector_stepper_tick_divider.sv
// Bit-period divider: counts 0..TICKS-1 while enabled and flags the final tick.
module tick_divider
    import stepper_pkg::*;
#(
    parameter int TICKS = DEF_TICKS_PER_BIT
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int TW = width_for(TICKS);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    assign last = (count_q == TW'(TICKS - 1));

    // Next count: clear wins, otherwise wrap after the final tick.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            if (last) begin
                count_d = '0;
            end else begin
                count_d = count_q + TW'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/detector_stepper.sv
// Run controller: clears the detector, feeds a latched pattern MSB-first at a fixed
// tick rate, samples the detector after each step and counts hits.
module detector_stepper
    import stepper_pkg::*;
#(
    parameter int PAT_W         = DEF_PAT_W,
    parameter int LEN_W         = DEF_LEN_W,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int TICKS_PER_BIT = DEF_TICKS_PER_BIT
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [PAT_W-1:0]     pattern,
    input  logic [LEN_W-1:0]     len,
    detector_stepper_if.master   det,
    output logic [CNT_W-1:0]     hit_count,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           state_out
);

    localparam int IDX_W = width_for(PAT_W);

    state_e             state_q, state_d;
    logic               start_q, start_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   hit_q, hit_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               clear_q, clear_d;

    logic               start_rise_s;
    logic [LEN_W-1:0]   len_clamped_s;
    logic               tick_last_s;
    logic               tick_clear_s;
    logic               tick_enable_s;

    assign start_rise_s  = start & ~start_q;
    assign len_clamped_s = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
    assign tick_clear_s  = (state_q == ST_CLEAR) || (state_q == ST_SAMPLE);
    assign tick_enable_s = (state_q == ST_DRIVE);

    tick_divider #(.TICKS(TICKS_PER_BIT)) u_tick (
        .clock  (clock),
        .resetn (resetn),
        .clear  (tick_clear_s),
        .enable (tick_enable_s),
        .last   (tick_last_s)
    );

    // The serial bit and the step pulse are decoded straight from registers so the
    // bit is stable for the whole DRIVE/SAMPLE window and the step lands on the last tick.
    assign det.det_w     = ((state_q == ST_DRIVE) || (state_q == ST_SAMPLE)) ? pat_q[idx_q] : 1'b0;
    assign det.det_step  = (state_q == ST_DRIVE) && tick_last_s;
    assign det.det_clear = clear_q;

    assign hit_count = hit_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_out = state_q;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        start_d = start;
        pat_d   = pat_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_rise_s) begin
                    hit_d = '0;
                    if (len == LEN_W'(0)) begin
                        state_d = ST_DONE;
                    end else begin
                        pat_d   = pattern;
                        idx_d   = IDX_W'(len_clamped_s - LEN_W'(1));
                        state_d = ST_CLEAR;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_CLEAR: begin
                state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (tick_last_s) begin
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_DRIVE;
                end
            end
            ST_SAMPLE: begin
                // Saturate rather than wrap so an oversize run never under-reports.
                if (det.det_z && (hit_q != {CNT_W{1'b1}})) begin
                    hit_d = hit_q + CNT_W'(1);
                end else begin
                    hit_d = hit_q;
                end
                if (idx_q == IDX_W'(0)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                    state_d = ST_DRIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d  = (state_d == ST_CLEAR) || (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
        done_d  = (state_d == ST_DONE);
        clear_d = (state_d == ST_CLEAR);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            pat_q   <= '0;
            idx_q   <= '0;
            hit_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            clear_q <= clear_d;
        end
    end

endmodule

// File: tb/tb_detector_stepper.sv
// Bench for detector_stepper: table vectors, randomized runs against a pattern-level
// reference, and hand sequences for reset, back-to-back and start-while-busy cases.
module tb_detector_stepper;

    localparam int PW = 16;
    localparam int TPB = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pattern = 16'd0;
    logic [4:0]  len = 5'd0;
    logic [4:0]  hit_count;
    logic        busy;
    logic        done;
    logic [2:0]  state_out;

    detector_stepper_if det_bus ();

    detector_stepper dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .pattern   (pattern),
        .len       (len),
        .det       (det_bus),
        .hit_count (hit_count),
        .busy      (busy),
        .done      (done),
        .state_out (state_out)
    );

    always #5 clock = ~clock;

    // Detector model: Moore z after an overlapping 1111 or 1101 since the last clear.
    logic [3:0] hist = 4'd0;
    always @(posedge clock) begin
        if (det_bus.det_clear) hist <= 4'd0;
        else if (det_bus.det_step) hist <= {hist[2:0], det_bus.det_w};
    end
    assign det_bus.det_z = (hist == 4'b1111) || (hist == 4'b1101);

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_lc(input int l);
        return (l > PW) ? PW : l;
    endfunction

    // Reference hit count from the bit stream the pattern describes.
    function automatic int ref_hits(input logic [15:0] p, input int l);
        int lc, h;
        logic [3:0] win;
        lc = ref_lc(l);
        h = 0;
        win = 4'd0;
        for (int i = lc - 1; i >= 0; i--) begin
            win = {win[2:0], p[i]};
            if (win == 4'b1111 || win == 4'b1101) h++;
        end
        return (h > 31) ? 31 : h;
    endfunction

    task automatic do_run(input string name, input logic [15:0] p, input logic [4:0] l,
                          input int exp_hits, input int exp_busy, input bit toggle);
        int cyc, busy_c, step_c, clr_c, ovl, first_clr, first_step, lc;
        bit got;
        logic [15:0] wseq, exp_w;
        logic [16:0] mask;
        lc = ref_lc(int'(l));
        cyc = 0; busy_c = 0; step_c = 0; clr_c = 0; ovl = 0;
        first_clr = -1; first_step = -1; got = 1'b0; wseq = 16'd0;
        @(negedge clock);
        start = 1'b0; pattern = p; len = l;
        @(negedge clock);
        start = 1'b1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clock);
            if (busy) busy_c++;
            if (det_bus.det_step) begin
                step_c++;
                wseq = {wseq[14:0], det_bus.det_w};
                if (first_step < 0) first_step = i;
            end
            if (det_bus.det_clear) begin
                clr_c++;
                if (first_clr < 0) first_clr = i;
            end
            if (det_bus.det_step && det_bus.det_clear) ovl++;
            // Inputs changing mid-run must not matter.
            pattern = ~pattern;
            len = len + 5'd3;
            if (toggle && i >= 3 && i <= 8) start = ~start;
            if (done) begin
                cyc = i;
                got = 1'b1;
                break;
            end
        end
        mask = (17'd1 << lc) - 17'd1;
        exp_w = p & mask[15:0];
        chk({name, " reached_done"}, 32'(got), 32'd1);
        chk({name, " latency"}, cyc, exp_busy + 1);
        chk({name, " busy_cycles"}, busy_c, exp_busy);
        chk({name, " step_count"}, step_c, lc);
        chk({name, " clear_count"}, clr_c, (lc > 0) ? 1 : 0);
        chk({name, " step_clear_overlap"}, ovl, 0);
        chk({name, " det_w_sequence"}, 32'(wseq), 32'(exp_w));
        if (lc > 0) chk({name, " clear_before_step"}, 32'(first_clr > 0 && first_clr < first_step), 32'd1);
        chk({name, " hit_count"}, 32'(hit_count), exp_hits);
        chk({name, " det_w_in_done"}, 32'(det_bus.det_w), 32'd0);
        repeat (3) @(negedge clock);
        chk({name, " hit_count_held"}, 32'(hit_count), exp_hits);
        chk({name, " done_held"}, 32'({done, busy, state_out}), 32'({1'b1, 1'b0, 3'd4}));
    endtask

    typedef struct {
        string       name;
        logic [15:0] p;
        logic [4:0]  l;
        int          hits;
        int          busy_cyc;
        bit          tog;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{"p1101_len4",     16'h000D, 5'd4,  1, 21, 1'b0};
        tbl[1] = '{"p1111111_len7",  16'h007F, 5'd7,  4, 36, 1'b0};
        tbl[2] = '{"p1101101_len7",  16'h006D, 5'd7,  2, 36, 1'b0};
        tbl[3] = '{"len0",           16'hFFFF, 5'd0,  0, 0,  1'b0};
        tbl[4] = '{"len20_clamp",    16'hFFFF, 5'd20, 13, 81, 1'b0};
        tbl[5] = '{"start_toggle",   16'h000D, 5'd4,  1, 21, 1'b1};
        tbl[6] = '{"b2b_first_1111", 16'h000F, 5'd4,  1, 21, 1'b0};
        tbl[7] = '{"b2b_second_1",   16'h0001, 5'd1,  0, 6,  1'b0};

        repeat (2) @(negedge clock);
        chk("reset_outputs", 32'({det_bus.det_w, det_bus.det_step, det_bus.det_clear, busy, done}), 32'd0);
        chk("reset_hit_state", 32'({hit_count, state_out}), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        chk("idle_after_reset", 32'({busy, done, state_out}), 32'd0);

        for (int k = 0; k < 8; k++)
            do_run(tbl[k].name, tbl[k].p, tbl[k].l, tbl[k].hits, tbl[k].busy_cyc, tbl[k].tog);

        for (int k = 0; k < 12; k++) begin
            logic [15:0] rp;
            logic [4:0]  rl;
            int          rlc;
            rp = 16'($urandom);
            rl = 5'($urandom_range(0, 20));
            rlc = ref_lc(int'(rl));
            do_run("random", rp, rl, ref_hits(rp, int'(rl)), (rlc > 0) ? (1 + rlc * (TPB + 1)) : 0, 1'b0);
        end

        // Asynchronous reset in the middle of DRIVE.
        @(negedge clock);
        start = 1'b0; pattern = 16'hFFFF; len = 5'd16;
        @(negedge clock);
        start = 1'b1;
        repeat (8) @(negedge clock);
        chk("midrun_was_busy", 32'(busy), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("midrun_reset_outputs", 32'({det_bus.det_w, det_bus.det_step, det_bus.det_clear, busy, done}), 32'd0);
        chk("midrun_reset_hit_state", 32'({hit_count, state_out}), 32'd0);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        begin
            int active;
            active = 0;
            repeat (6) begin
                @(negedge clock);
                if (busy || state_out != 3'd0 || det_bus.det_clear) active++;
            end
            chk("no_run_after_reset", active, 0);
        end
        do_run("after_reset_run", 16'h006D, 5'd7, 2, 36, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
